// File: rtl/clk_enable_bus_bridge.sv
// Quarter-rate core to full-rate memory bridge: captures the core request on
// clk_enable_n, runs a valid/ready access at full rate, and stalls the core until done.
module clk_enable_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        clk_enable_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        err,
    output logic        stall,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0]    state_q,     state_d;
    logic          stall_q,     stall_d;
    logic          mem_valid_q, mem_valid_d;
    logic          mem_we_q,    mem_we_d;
    logic [31:0]   mem_addr_q,  mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q,    mem_be_d;
    logic [31:0]   rdata_q,     rdata_d;
    logic          err_q,       err_d;
    logic [CW-1:0] cnt_q,       cnt_d;

    always_comb begin
        state_d     = state_q;
        stall_d     = stall_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (clk_enable_n && req) begin
                    mem_we_d    = we;
                    mem_addr_d  = addr;
                    mem_wdata_d = wdata;
                    mem_be_d    = be;
                    mem_valid_d = 1'b1;
                    stall_d     = 1'b1;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // A ready arriving on the expiry cycle still completes normally.
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = HOLD;
                end else if (cnt_q >= CNT_LAST) begin
                    mem_valid_d = 1'b0;
                    err_d       = 1'b1;
                    if (!mem_we_q) begin
                        rdata_d = ERR_RDATA;
                    end
                    state_d = HOLD;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                // Dropping stall on clk_enable_n keeps it low ahead of the next core edge.
                if (clk_enable_n) begin
                    stall_d = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (clk_enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            stall_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rdata     = rdata_q;
    assign err       = err_q;
    assign stall     = stall_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_clk_enable_bus_bridge.sv
// Bench for clk_enable_bus_bridge: quarter-rate core emulation, a memory model
// with configurable wait states, and a scoreboard of expected memory transactions.
module tb_clk_enable_bus_bridge;

    localparam int unsigned TIMEOUT = 16;
    localparam logic [31:0] ERR_RD  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        clk_enable_n;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
    logic        stall;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    clk_enable_bus_bridge #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .ERR_RDATA     (ERR_RD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .clk_enable_n(clk_enable_n),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .be          (be),
        .rdata       (rdata),
        .err         (err),
        .stall       (stall),
        .mem_valid   (mem_valid),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t        sb[$];
    int          tests_run = 0;
    int          fails     = 0;
    int          hs_count  = 0;
    int          cyc       = 0;
    int          mem_mode  = 0;   // 0: wait_n wait states, 1: never ready, 2: ready always high
    int          wait_n    = 0;
    logic [31:0] resp_data = 32'h0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Enable phases and memory responses change 2ns after each edge.
    initial begin
        int ph;
        int wcnt;
        ph = 0;
        wcnt = 0;
        clk_enable = 1'b0;
        clk_enable_n = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            ph = (ph + 1) % 4;
            clk_enable   = (ph == 0);
            clk_enable_n = (ph == 2);
            mem_rdata    = resp_data;
            if (mem_mode == 2) begin
                mem_ready = 1'b1;
            end else if (mem_mode == 0 && mem_valid === 1'b1) begin
                mem_ready = (wcnt == wait_n);
                wcnt++;
            end else begin
                mem_ready = 1'b0;
            end
            if (mem_valid !== 1'b1) wcnt = 0;
        end
    end

    // Scoreboard: every completed handshake must match the oldest expected transaction.
    initial begin
        txn_t e;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1 && mem_ready === 1'b1) begin
                hs_count++;
                tests_run++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got addr=%h we=%b, expected no transaction", mem_addr, mem_we);
                end else begin
                    e = sb.pop_front();
                    if (mem_we !== e.we || mem_addr !== e.addr || mem_wdata !== e.wdata || mem_be !== e.be) begin
                        fails++;
                        $display("FAIL sb_txn: got we=%b addr=%h wdata=%h be=%b, expected we=%b addr=%h wdata=%h be=%b",
                                 mem_we, mem_addr, mem_wdata, mem_be, e.we, e.addr, e.wdata, e.be);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Cycle (relative to capture cycle N) at which stall is first seen low, given the
    // last cycle mem_valid was high: the first clk_enable_n (N+4m) after it, plus one.
    function automatic int exp_fall(input int last_valid_k);
        int j;
        j = last_valid_k + 1;
        while (j % 4 != 0) j++;
        return j + 1;
    endfunction

    // Leaves the bench at a negedge just after a clk_enable edge.
    task automatic sync_after_ce(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (clk_enable === 1'b1) ok = 1'b1;
        end
        @(negedge clk);
    endtask

    // Core side: present a request and follow it until the core advances on clk_enable.
    task automatic core_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] b, input bit expect_hs,
                               output int first_valid_k, output int valid_cnt, output int fall_k,
                               output bit stable, output logic err_at_cap, output bit done);
        int c0;
        int k;
        bit seen_stall;
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        if (expect_hs) sb.push_back('{we: w, addr: a, wdata: d, be: b});
        c0 = cyc;
        first_valid_k = -1; valid_cnt = 0; fall_k = -1; stable = 1'b1;
        err_at_cap = 1'bx; done = 1'b0; seen_stall = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            k = cyc - (c0 + 1);
            if (k == 1) err_at_cap = err;
            if (mem_valid === 1'b1) begin
                if (first_valid_k < 0) first_valid_k = k;
                valid_cnt++;
                if (mem_we !== w || mem_addr !== a || mem_wdata !== d || mem_be !== b) stable = 1'b0;
            end
            if (stall === 1'b1) seen_stall = 1'b1;
            else if (seen_stall && fall_k < 0) fall_k = k;
            if (seen_stall && stall === 1'b0 && clk_enable === 1'b1) done = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        repeat (4) @(negedge clk);
        tests_run++;
        if ({stall, mem_valid, mem_we, mem_addr, mem_wdata, mem_be, rdata, err} !== '0) begin
            fails++;
            $display("FAIL reset_values: got stall=%b valid=%b we=%b addr=%h wdata=%h be=%b rdata=%h err=%b, expected all zero",
                     stall, mem_valid, mem_we, mem_addr, mem_wdata, mem_be, rdata, err);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (stall !== 1'b0 || mem_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got stall=%b valid=%b, expected 0 0", stall, mem_valid);
        end
    endtask

    task automatic test_zero_wait_load();
        bit ok, stable, done;
        int fv, vc, fk;
        logic ec;
        mem_mode = 0; wait_n = 0; resp_data = 32'hCAFE_F00D;
        sync_after_ce(ok);
        core_access(1'b0, 32'h100, 32'hAAAA_5555, 4'hF, 1'b1, fv, vc, fk, stable, ec, done);
        req = 1'b0;
        tests_run++;
        if (!ok || !done) begin fails++; $display("FAIL zw_done: got sync=%b done=%b, expected 1 1", ok, done); end
        tests_run++;
        if (fv != 1 || vc != 1) begin fails++; $display("FAIL zw_valid: got first=%0d count=%0d, expected 1 1", fv, vc); end
        tests_run++;
        if (fk != exp_fall(1)) begin fails++; $display("FAIL zw_stall_fall: got %0d, expected %0d", fk, exp_fall(1)); end
        tests_run++;
        if (mem_addr !== 32'h100 || !stable) begin fails++; $display("FAIL zw_addr: got %h stable=%b, expected 00000100 1", mem_addr, stable); end
        tests_run++;
        if (rdata !== 32'hCAFE_F00D || err !== 1'b0) begin
            fails++; $display("FAIL zw_rdata: got rdata=%h err=%b, expected cafef00d 0", rdata, err);
        end
    endtask

    task automatic test_wait_store();
        bit ok, stable, done;
        int fv, vc, fk;
        logic ec;
        mem_mode = 0; wait_n = 7; resp_data = 32'hBAD0_BAD0;
        sync_after_ce(ok);
        core_access(1'b1, 32'h204, 32'h1234_5678, 4'b0011, 1'b1, fv, vc, fk, stable, ec, done);
        req = 1'b0;
        tests_run++;
        if (!ok || !done) begin fails++; $display("FAIL ws_done: got sync=%b done=%b, expected 1 1", ok, done); end
        tests_run++;
        if (vc != 8 || !stable) begin fails++; $display("FAIL ws_stable: got valid_cycles=%0d stable=%b, expected 8 1", vc, stable); end
        tests_run++;
        if (fk != exp_fall(8)) begin fails++; $display("FAIL ws_stall_fall: got %0d, expected %0d", fk, exp_fall(8)); end
        tests_run++;
        if (mem_wdata !== 32'h1234_5678 || mem_be !== 4'b0011 || mem_we !== 1'b1) begin
            fails++; $display("FAIL ws_fields: got wdata=%h be=%b we=%b, expected 12345678 0011 1", mem_wdata, mem_be, mem_we);
        end
        tests_run++;
        if (rdata !== 32'hCAFE_F00D || err !== 1'b0) begin
            fails++; $display("FAIL ws_rdata_kept: got rdata=%h err=%b, expected cafef00d 0", rdata, err);
        end
    endtask

    task automatic test_timeout();
        bit ok, stable, done;
        int fv, vc, fk;
        logic ec;
        mem_mode = 1;
        sync_after_ce(ok);
        core_access(1'b0, 32'h200, 32'h0, 4'hF, 1'b0, fv, vc, fk, stable, ec, done);
        req = 1'b0;
        tests_run++;
        if (!ok || !done) begin fails++; $display("FAIL to_done: got sync=%b done=%b, expected 1 1", ok, done); end
        tests_run++;
        if (vc != int'(TIMEOUT)) begin fails++; $display("FAIL to_valid_cycles: got %0d, expected %0d", vc, TIMEOUT); end
        tests_run++;
        if (err !== 1'b1 || rdata !== ERR_RD) begin
            fails++; $display("FAIL to_err: got err=%b rdata=%h, expected 1 %h", err, rdata, ERR_RD);
        end
        tests_run++;
        if (fk != exp_fall(int'(TIMEOUT))) begin
            fails++; $display("FAIL to_stall_fall: got %0d, expected %0d", fk, exp_fall(int'(TIMEOUT)));
        end
        mem_mode = 0; wait_n = 0; resp_data = 32'h55AA_33CC;
        sync_after_ce(ok);
        core_access(1'b0, 32'h300, 32'h0, 4'hF, 1'b1, fv, vc, fk, stable, ec, done);
        req = 1'b0;
        tests_run++;
        if (!done || ec !== 1'b0 || err !== 1'b0 || rdata !== 32'h55AA_33CC) begin
            fails++; $display("FAIL to_err_clear: got done=%b err_at_capture=%b err=%b rdata=%h, expected 1 0 0 55aa33cc",
                              done, ec, err, rdata);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, s1, s2, d1, d2;
        int fv1, fv2, vc1, vc2, fk1, fk2, hs0;
        logic e1, e2;
        mem_mode = 0; wait_n = 0; resp_data = 32'h1111_2222;
        hs0 = hs_count;
        sync_after_ce(ok);
        core_access(1'b0, 32'h400, 32'h0, 4'hF, 1'b1, fv1, vc1, fk1, s1, e1, d1);
        @(negedge clk);
        resp_data = 32'h3333_4444;
        core_access(1'b0, 32'h404, 32'h0, 4'hF, 1'b1, fv2, vc2, fk2, s2, e2, d2);
        req = 1'b0;
        repeat (12) @(negedge clk);
        tests_run++;
        if (!ok || !d1 || !d2 || fv2 != 1 || vc1 != 1 || vc2 != 1) begin
            fails++; $display("FAIL b2b_timing: got done=%b%b first_valid2=%0d counts=%0d,%0d, expected 11 1 1,1",
                              d1, d2, fv2, vc1, vc2);
        end
        tests_run++;
        if (hs_count - hs0 != 2 || sb.size() != 0) begin
            fails++; $display("FAIL b2b_count: got %0d transactions, %0d pending, expected 2 0", hs_count - hs0, sb.size());
        end
        tests_run++;
        if (rdata !== 32'h3333_4444) begin fails++; $display("FAIL b2b_rdata: got %h, expected 33334444", rdata); end
    endtask

    task automatic test_req_on_ce_only();
        bit ok, quiet;
        int hs0;
        hs0 = hs_count;
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (clk_enable === 1'b1) ok = 1'b1;
        end
        req = 1'b1; we = 1'b0; addr = 32'h500;
        @(negedge clk);
        req = 1'b0;
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (mem_valid !== 1'b0 || stall !== 1'b0) quiet = 1'b0;
        end
        tests_run++;
        if (!ok || !quiet || hs_count != hs0) begin
            fails++; $display("FAIL ce_only_req: got sync=%b quiet=%b transactions=%0d, expected 1 1 0", ok, quiet, hs_count - hs0);
        end
    endtask

    task automatic test_reset_in_issue();
        bit ok, quiet, stable, done;
        int hs0, fv, vc, fk;
        logic ec;
        hs0 = hs_count;
        mem_mode = 1;
        sync_after_ce(ok);
        req = 1'b1; we = 1'b0; addr = 32'h600; wdata = '0; be = 4'hF;
        repeat (2) @(negedge clk);
        tests_run++;
        if (!ok || mem_valid !== 1'b1 || stall !== 1'b1) begin
            fails++; $display("FAIL rst_issue_pre: got sync=%b valid=%b stall=%b, expected 1 1 1", ok, mem_valid, stall);
        end
        reset = 1'b1; req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem_valid !== 1'b0 || stall !== 1'b0 || rdata !== '0 || err !== 1'b0) begin
            fails++; $display("FAIL rst_issue_abort: got valid=%b stall=%b rdata=%h err=%b, expected 0 0 00000000 0",
                              mem_valid, stall, rdata, err);
        end
        reset = 1'b0; mem_mode = 2; resp_data = 32'hDEAD_BEEF;
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (mem_valid !== 1'b0 || stall !== 1'b0 || rdata !== '0) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet || hs_count != hs0) begin
            fails++; $display("FAIL rst_ready_ignored: got quiet=%b transactions=%0d, expected 1 0", quiet, hs_count - hs0);
        end
        mem_mode = 0; wait_n = 0; resp_data = 32'h0BAD_CAFE;
        sync_after_ce(ok);
        core_access(1'b0, 32'h700, 32'h0, 4'hF, 1'b1, fv, vc, fk, stable, ec, done);
        req = 1'b0;
        tests_run++;
        if (!done || fv != 1 || rdata !== 32'h0BAD_CAFE) begin
            fails++; $display("FAIL rst_then_idle: got done=%b first_valid=%0d rdata=%h, expected 1 1 0badcafe", done, fv, rdata);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_load();
        test_wait_store();
        test_timeout();
        test_back_to_back();
        test_req_on_ce_only();
        test_reset_in_issue();
        repeat (4) @(negedge clk);
        tests_run++;
        if (sb.size() != 0) begin fails++; $display("FAIL sb_drain: got %0d pending, expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
